// File: rtl/config_chain_loader_pkg.sv
// Shared fabric configuration package for the configuration chain loader.
// Holds the loader state encoding and the default bitstream word width and
// chain length used when the loader is instantiated without overrides.
package config_chain_loader_pkg;

    localparam int unsigned DEFAULT_WORD_W    = 32;
    localparam int unsigned DEFAULT_CHAIN_LEN = 120;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        SET   = 2'd3
    } loader_state_t;

endpackage

// File: rtl/cfg_bit_counter.sv
// Saturating up-counter with synchronous clear and a terminal-count flag.
// Ports:
//   clk   - clock, all state on rising edge
//   rst   - asynchronous active-low reset
//   clr   - synchronous clear (priority over en)
//   en    - count enable
//   count - current count, saturates at LIMIT so it can never wrap
//   tc    - high while count == LIMIT-1, i.e. the next enabled edge
//           completes the run
module cfg_bit_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LIMIT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);
    localparam logic [WIDTH-1:0] FULL = WIDTH'(LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != FULL)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/config_chain_loader.sv
// Loads a serial configuration chain from a stream of bitstream words.
// Each accepted word is shifted out LSB first with cen high; the last word is
// truncated so exactly CHAIN_LEN bits reach the chain, then one set_in/cen
// cycle commits the chain and done pulses on the following cycle. The bits
// falling out of the chain end are gathered into one readback word per
// shifted word.
// Ports:
//   clk, rst              - clock and asynchronous active-low reset
//   start, abort          - begin a load / cancel a load in progress
//   word_valid/ready/data - bitstream word handshake
//   cen, shift_in, set_in - registered chain controls
//   shift_out             - serial bit returned from the chain end
//   rb_valid, rb_data     - readback strobe and word
//   busy, done            - loader active / one-cycle completion pulse
module config_chain_loader
    import config_chain_loader_pkg::*;
#(
    parameter int unsigned WORD_W    = DEFAULT_WORD_W,
    parameter int unsigned CHAIN_LEN = DEFAULT_CHAIN_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic [WORD_W-1:0] word_data,
    output logic              cen,
    output logic              shift_in,
    output logic              set_in,
    input  logic              shift_out,
    output logic              rb_valid,
    output logic [WORD_W-1:0] rb_data,
    output logic              busy,
    output logic              done
);

    localparam int unsigned TOTAL_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WCNT_W  = $clog2(WORD_W + 1);

    loader_state_t state_reg, state_next;

    logic [WORD_W-1:0]  shift_reg;
    logic [WORD_W-1:0]  rb_reg;
    logic               cen_reg, cen_next;
    logic               shift_in_reg, shift_in_next;
    logic               set_in_reg, set_in_next;
    logic               rb_valid_reg;
    logic               done_reg;

    logic [TOTAL_W-1:0] total_cnt;
    logic               total_last;
    logic [WCNT_W-1:0]  word_cnt;
    logic               word_last;
    logic               unused_total;

    logic               launch;
    logic               handshake;
    logic               shifting;
    logic               shift_end;

    // abort wins over start and over a word handshake in the same cycle
    assign launch    = (state_reg == IDLE) && start && !abort;
    assign handshake = (state_reg == LOAD) && word_valid && !abort;
    assign shifting  = (state_reg == SHIFT) && !abort;
    // a word's run ends on its last bit or on the last bit of the chain,
    // whichever comes first, so surplus bits of the final word are dropped
    assign shift_end = shifting && (word_last || total_last);

    cfg_bit_counter #(
        .WIDTH (TOTAL_W),
        .LIMIT (CHAIN_LEN)
    ) u_total_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (launch),
        .en    (shifting),
        .count (total_cnt),
        .tc    (total_last)
    );

    cfg_bit_counter #(
        .WIDTH (WCNT_W),
        .LIMIT (WORD_W)
    ) u_word_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (handshake),
        .en    (shifting),
        .count (word_cnt),
        .tc    (word_last)
    );

    // only the terminal flag of the total counter drives the FSM
    assign unused_total = ^total_cnt;

    always_comb begin
        state_next    = state_reg;
        cen_next      = 1'b0;
        set_in_next   = 1'b0;
        shift_in_next = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (launch) state_next = LOAD;
            end
            LOAD: begin
                if (abort)           state_next = IDLE;
                else if (word_valid) state_next = SHIFT;
            end
            SHIFT: begin
                if (abort)          state_next = IDLE;
                else if (shift_end) state_next = total_last ? SET : LOAD;
            end
            SET: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // chain controls are registered, so they are computed from the
        // state being entered and line up with it on the next cycle
        cen_next    = (state_next == SHIFT) || (state_next == SET);
        set_in_next = (state_next == SET);
        if (handshake) begin
            shift_in_next = word_data[0];
        end else if (shifting && !shift_end) begin
            shift_in_next = shift_reg[0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            rb_reg       <= '0;
            cen_reg      <= 1'b0;
            shift_in_reg <= 1'b0;
            set_in_reg   <= 1'b0;
            rb_valid_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cen_reg      <= cen_next;
            shift_in_reg <= shift_in_next;
            set_in_reg   <= set_in_next;
            rb_valid_reg <= shift_end;
            done_reg     <= (state_reg == SET) && !abort;
            if (handshake) begin
                // bit 0 is presented on shift_in_reg directly, so the
                // register keeps the remaining bits ready for the next cycle
                shift_reg <= word_data >> 1;
                rb_reg    <= '0;
            end else if (shifting) begin
                shift_reg <= shift_reg >> 1;
                rb_reg    <= rb_reg | (WORD_W'(shift_out) << word_cnt);
            end
        end
    end

    assign word_ready = (state_reg == LOAD) && !abort;
    assign cen        = cen_reg;
    assign shift_in   = shift_in_reg;
    assign set_in     = set_in_reg;
    assign rb_valid   = rb_valid_reg;
    assign rb_data    = rb_reg;
    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: a 120-bit loader and a 32-bit loader, each
// driving a behavioural flop chain whose end loops back to shift_out.
// Expected bitstreams, readback words and timing come from a bit-queue model
// of the chain fed with the words handed to the loader.
module tb_config_chain_loader;

    localparam int WW    = 32;
    localparam int LEN_A = 120;
    localparam int LEN_B = 32;
    localparam logic [LEN_A-1:0] INIT_A = 120'h7D5A3C96E10F872D4BC3A5F01E69B2;
    localparam logic [LEN_B-1:0] INIT_B = 32'hC0FFEE42;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst        = 1'b0;
    logic          start      = 1'b0;
    logic          abort      = 1'b0;
    logic          word_valid = 1'b0;
    logic [WW-1:0] word_data  = '0;
    int            dsel       = 0;

    logic a_ready, a_cen, a_sin, a_set, a_sout, a_rbv, a_busy, a_done;
    logic b_ready, b_cen, b_sin, b_set, b_sout, b_rbv, b_busy, b_done;
    logic [WW-1:0] a_rbd, b_rbd;

    config_chain_loader #(.WORD_W(WW), .CHAIN_LEN(LEN_A)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .start      (start && (dsel == 0)),
        .abort      (abort && (dsel == 0)),
        .word_valid (word_valid && (dsel == 0)),
        .word_ready (a_ready),
        .word_data  (word_data),
        .cen        (a_cen),
        .shift_in   (a_sin),
        .set_in     (a_set),
        .shift_out  (a_sout),
        .rb_valid   (a_rbv),
        .rb_data    (a_rbd),
        .busy       (a_busy),
        .done       (a_done)
    );

    config_chain_loader #(.WORD_W(WW), .CHAIN_LEN(LEN_B)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .start      (start && (dsel != 0)),
        .abort      (abort && (dsel != 0)),
        .word_valid (word_valid && (dsel != 0)),
        .word_ready (b_ready),
        .word_data  (word_data),
        .cen        (b_cen),
        .shift_in   (b_sin),
        .set_in     (b_set),
        .shift_out  (b_sout),
        .rb_valid   (b_rbv),
        .rb_data    (b_rbd),
        .busy       (b_busy),
        .done       (b_done)
    );

    // target chains: shift on cen, hold during the commit (set_in) cycle
    logic [LEN_A-1:0] chain_a = INIT_A;
    logic [LEN_B-1:0] chain_b = INIT_B;
    always @(posedge clk) if (a_cen && !a_set) chain_a <= {chain_a[LEN_A-2:0], a_sin};
    always @(posedge clk) if (b_cen && !b_set) chain_b <= {chain_b[LEN_B-2:0], b_sin};
    assign a_sout = chain_a[LEN_A-1];
    assign b_sout = chain_b[LEN_B-1];

    // view of the loader currently under test
    logic m_ready, m_cen, m_sin, m_set, m_rbv, m_busy, m_done;
    logic [WW-1:0] m_rbd;
    assign m_ready = (dsel != 0) ? b_ready : a_ready;
    assign m_cen   = (dsel != 0) ? b_cen   : a_cen;
    assign m_sin   = (dsel != 0) ? b_sin   : a_sin;
    assign m_set   = (dsel != 0) ? b_set   : a_set;
    assign m_rbv   = (dsel != 0) ? b_rbv   : a_rbv;
    assign m_busy  = (dsel != 0) ? b_busy  : a_busy;
    assign m_done  = (dsel != 0) ? b_done  : a_done;
    assign m_rbd   = (dsel != 0) ? b_rbd   : a_rbd;

    int total = 0;
    int bad   = 0;

    // model of chain contents, front = bit that leaves the chain next
    bit ref_a[$];
    bit ref_b[$];
    logic [WW-1:0] wq[$];
    logic [WW-1:0] last_rbs[$];

    function automatic bit ref_step(input bit b);
        bit o;
        if (dsel != 0) begin
            o = ref_b.pop_front();
            ref_b.push_back(b);
        end else begin
            o = ref_a.pop_front();
            ref_a.push_back(b);
        end
        return o;
    endfunction

    // cut_mode: 0 full load, 1 abort when cut_at bits seen, 2 reset then
    task automatic run_load(input int nw, input int stall_idx, input int stall_len,
                            input bit rand_stall, input int cut_mode, input int cut_at,
                            input bit hold_start, input bit check_lat);
        int clen, cyc, idx, n_set, n_done, set_cyc, done_cyc, stall_left, post;
        int committed, n_rb_exp, n_cmp, errs, first_bad;
        bit hs, cut, finished, ob;
        bit bits[$];
        bit exp_bits[$];
        logic [WW-1:0] rbs[$];
        logic [WW-1:0] rb_exp[$];
        logic [WW-1:0] w;
        clen = (dsel != 0) ? LEN_B : LEN_A;
        cyc = 0; idx = 0; n_set = 0; n_done = 0; set_cyc = -1; done_cyc = -1;
        stall_left = stall_len; post = 0; hs = 0; cut = 0; finished = 0;
        for (int j = 0; j < clen; j++) begin
            w = wq[j / WW];
            exp_bits.push_back(w[j % WW]);
        end
        while (!finished) begin
            @(negedge clk);
            #1;
            if (hs) idx++;
            if (m_cen && !m_set) bits.push_back(m_sin);
            if (m_set) begin n_set++; set_cyc = cyc; end
            if (m_rbv) rbs.push_back(m_rbd);
            if (m_done) begin n_done++; done_cyc = cyc; end
            if (cut) begin
                post++;
                if (post == 1) begin
                    total++;
                    if (m_busy !== 1'b0 || m_cen !== 1'b0)
                        $display("FAIL cut_idle: busy=%b cen=%b want 0 0", m_busy, m_cen);
                    if (m_busy !== 1'b0 || m_cen !== 1'b0) bad++;
                end
                if (cut_mode == 2 && post == 3) rst = 1'b1;
                if (post >= 12) finished = 1;
            end else if (n_done > 0) begin
                post++;
                if (post >= 3) finished = 1;
            end
            start      = (cyc == 0) || (hold_start && n_done == 0);
            abort      = 1'b0;
            word_valid = 1'b0;
            if (!cut && idx < nw) begin
                if (stall_left > 0 && idx == stall_idx && m_ready) begin
                    stall_left--;
                    total++;
                    if (m_cen !== 1'b0) begin
                        bad++;
                        $display("FAIL stall_cen: cen=%b want 0", m_cen);
                    end
                end else begin
                    word_valid = rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                    word_data  = wq[idx];
                end
            end
            if (!cut && cut_mode != 0 && bits.size() == cut_at) begin
                cut = 1;
                start = 1'b0;
                if (cut_mode == 1) begin
                    abort = 1'b1;
                end else begin
                    #1 rst = 1'b0;
                    #1;
                    total++;
                    if ({m_cen, m_sin, m_set, m_ready, m_rbv, m_busy, m_done, m_rbd} !== '0) begin
                        bad++;
                        $display("FAIL async_rst: outs=%b rb=%h want all 0",
                                 {m_cen, m_sin, m_set, m_ready, m_rbv, m_busy, m_done}, m_rbd);
                    end
                end
            end
            #1;
            hs = word_valid && m_ready;
            cyc++;
            if (cyc > 600) begin
                total++; bad++;
                $display("FAIL timeout: cycles=%0d done=%0d want done within 600", cyc, n_done);
                finished = 1;
            end
        end
        start = 1'b0; abort = 1'b0; word_valid = 1'b0; rst = 1'b1;

        // advance the chain model by the bits that really entered the chain
        committed = (cut_mode == 0) ? clen : ((cut_mode == 1) ? cut_at : cut_at - 1);
        for (int k = 0; k < (clen + WW - 1) / WW; k++) rb_exp.push_back('0);
        for (int j = 0; j < committed; j++) begin
            ob = ref_step(exp_bits[j]);
            w = rb_exp[j / WW];
            w[j % WW] = ob;
            rb_exp[j / WW] = w;
        end
        n_rb_exp = (cut_mode == 0) ? nw : committed / WW;
        n_cmp    = (cut_mode == 0) ? clen : cut_at;

        total++;
        if (bits.size() != n_cmp) begin
            bad++;
            $display("FAIL shift_count: got %0d cen cycles want %0d", bits.size(), n_cmp);
        end
        errs = 0; first_bad = -1;
        for (int j = 0; j < n_cmp && j < bits.size(); j++) begin
            if (bits[j] != exp_bits[j]) begin
                errs++;
                if (first_bad < 0) first_bad = j;
            end
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL stream: got %0d wrong bits (first at %0d) want 0", errs, first_bad);
        end
        total++;
        if (n_set != ((cut_mode == 0) ? 1 : 0)) begin
            bad++;
            $display("FAIL set_in_count: got %0d want %0d", n_set, (cut_mode == 0) ? 1 : 0);
        end
        total++;
        if (n_done != ((cut_mode == 0) ? 1 : 0)) begin
            bad++;
            $display("FAIL done_count: got %0d want %0d", n_done, (cut_mode == 0) ? 1 : 0);
        end
        if (cut_mode == 0) begin
            total++;
            if (done_cyc != set_cyc + 1) begin
                bad++;
                $display("FAIL done_timing: done at %0d want %0d", done_cyc, set_cyc + 1);
            end
            total++;
            if (idx != nw) begin
                bad++;
                $display("FAIL words_taken: got %0d want %0d", idx, nw);
            end
        end
        if (check_lat) begin
            total++;
            if (set_cyc != nw + clen + 1 + stall_len) begin
                bad++;
                $display("FAIL latency: set_in at cycle %0d want %0d", set_cyc, nw + clen + 1 + stall_len);
            end
        end
        if (stall_len > 0) begin
            total++;
            if (stall_left != 0) begin
                bad++;
                $display("FAIL stall_seen: %0d stall cycles unused want 0", stall_left);
            end
        end
        total++;
        if (rbs.size() != n_rb_exp) begin
            bad++;
            $display("FAIL rb_count: got %0d want %0d", rbs.size(), n_rb_exp);
        end
        for (int k = 0; k < rbs.size() && k < n_rb_exp; k++) begin
            total++;
            if (rbs[k] !== rb_exp[k]) begin
                bad++;
                $display("FAIL rb_word%0d: got %h want %h", k, rbs[k], rb_exp[k]);
            end
        end
        total++;
        if (m_busy !== 1'b0) begin
            bad++;
            $display("FAIL end_idle: busy=%b want 0", m_busy);
        end
        last_rbs = rbs;
        $display("load sel=%0d words=%0d cut=%0d bits=%0d set=%0d done=%0d rb=%0d",
                 dsel, nw, cut_mode, bits.size(), n_set, n_done, rbs.size());
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({a_cen, a_sin, a_set, a_ready, a_rbv, a_busy, a_done, a_rbd} !== '0) begin
            bad++;
            $display("FAIL reset_a: outs=%b rb=%h want all 0",
                     {a_cen, a_sin, a_set, a_ready, a_rbv, a_busy, a_done}, a_rbd);
        end
        total++;
        if ({b_cen, b_sin, b_set, b_ready, b_rbv, b_busy, b_done, b_rbd} !== '0) begin
            bad++;
            $display("FAIL reset_b: outs=%b rb=%h want all 0",
                     {b_cen, b_sin, b_set, b_ready, b_rbv, b_busy, b_done}, b_rbd);
        end
        #1 rst = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if ({a_cen, a_sin, a_set, a_ready, a_rbv, a_busy, a_done, a_rbd} !== '0) begin
            bad++;
            $display("FAIL post_reset_a: outs=%b rb=%h want all 0",
                     {a_cen, a_sin, a_set, a_ready, a_rbv, a_busy, a_done}, a_rbd);
        end
        total++;
        if ({b_cen, b_sin, b_set, b_ready, b_rbv, b_busy, b_done, b_rbd} !== '0) begin
            bad++;
            $display("FAIL post_reset_b: outs=%b rb=%h want all 0",
                     {b_cen, b_sin, b_set, b_ready, b_rbv, b_busy, b_done}, b_rbd);
        end
        $display("reset checked");
    endtask

    task automatic load_fixed_words();
        wq.delete();
        wq.push_back(32'hDEADBEEF);
        wq.push_back(32'h01234567);
        wq.push_back(32'h89ABCDEF);
        wq.push_back(32'h00FFFFFF);
    endtask

    task automatic load_random_words(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back($urandom());
    endtask

    task automatic test_basic();
        dsel = 0;
        load_fixed_words();
        run_load(4, -1, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_loopback();
        logic [WW-1:0] want;
        dsel = 0;
        load_fixed_words();
        run_load(4, -1, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 4 && k < last_rbs.size(); k++) begin
            want = wq[k];
            if (k == 3) want = want & 32'h00FFFFFF;
            total++;
            if (last_rbs[k] !== want) begin
                bad++;
                $display("FAIL loopback%0d: got %h want %h", k, last_rbs[k], want);
            end
        end
    endtask

    task automatic test_stall();
        dsel = 0;
        load_fixed_words();
        run_load(4, 2, 5, 0, 0, 0, 0, 1);
    endtask

    task automatic test_abort();
        dsel = 0;
        load_random_words(4);
        run_load(4, -1, 0, 0, 1, 40, 0, 0);
        load_random_words(4);
        run_load(4, -1, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_random();
        dsel = 0;
        for (int r = 0; r < 3; r++) begin
            load_random_words(4);
            run_load(4, -1, 0, 1, 0, 0, 0, 0);
        end
    endtask

    task automatic test_async_reset();
        dsel = 0;
        load_random_words(4);
        run_load(4, -1, 0, 0, 2, 50, 0, 0);
        load_random_words(4);
        run_load(4, -1, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_start_held();
        dsel = 1;
        load_random_words(1);
        run_load(1, -1, 0, 0, 0, 0, 1, 1);
        load_random_words(1);
        run_load(1, -1, 0, 1, 0, 0, 0, 0);
        dsel = 0;
    endtask

    initial begin
        logic [LEN_A-1:0] ia;
        logic [LEN_B-1:0] ib;
        ia = INIT_A;
        ib = INIT_B;
        for (int i = LEN_A - 1; i >= 0; i--) ref_a.push_back(ia[i]);
        for (int i = LEN_B - 1; i >= 0; i--) ref_b.push_back(ib[i]);
        test_reset();
        test_basic();
        test_loopback();
        test_stall();
        test_abort();
        test_random();
        test_async_reset();
        test_start_held();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
